// File: rtl/qspi_flash_responder_pkg.sv
// qspi_flash_responder_pkg: shared QSPI command codes, lane width and default dummy count
package qspi_flash_responder_pkg;
    typedef enum logic [7:0] {
        CmdReset   = 8'h99,
        CmdPowerUp = 8'hAB,
        CmdRead    = 8'hEB
    } cmd_t;
    localparam int NIBBLE_W             = 4;
    localparam int DEFAULT_DUMMY_CYCLES = 6;
endpackage

// File: rtl/qspi_shift_in.sv
// qspi_shift_in: MSB-first shift register of COUNT lanes of LANE_W bits, flagging the final capture
module qspi_shift_in
    import qspi_flash_responder_pkg::*;
#(
    parameter int LANE_W = NIBBLE_W,
    parameter int COUNT  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [LANE_W-1:0]       din_i,
    output logic [LANE_W*COUNT-1:0] value_o,
    output logic                    done_o
);
    localparam int W    = LANE_W * COUNT;
    localparam int CW   = $clog2(COUNT + 1);
    logic [W-1:0]        data_q;
    logic [CW-1:0]       cnt_q;
    logic [W+LANE_W-1:0] shifted;
    // value_o already contains the lane arriving this cycle so the caller can decode on the last edge
    assign shifted = {data_q, din_i};
    assign value_o = shifted[W-1:0];
    assign done_o  = en_i && (cnt_q == CW'(COUNT - 1));
    // shift one lane per enabled cycle; the counter restarts after the last lane or on clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            data_q <= value_o;
            cnt_q  <= done_o ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: QSPI flash target for reset/power-up/quad-read; QSPI_RESPONDER_WRAP_EN wraps reads in 16-byte lines
module qspi_flash_responder
    import qspi_flash_responder_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = DEFAULT_DUMMY_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic              io_oe,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              powered
);
    localparam int CNT_W = $clog2(DUMMY_CYCLES);

    typedef enum logic [2:0] {Asleep, Idle, Cmd, Addr, Dummy, Data, Ignore} state_t;

    state_t            state_q, state_d;
    logic              powered_q, powered_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              half_q, half_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        io_out_q, io_out_d;
    logic              io_oe_q, io_oe_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              cmd_en, cmd_done, addr_en, addr_done, fetch;
    logic [7:0]        cmd_val;
    logic [ADDR_W-1:0] addr_val, fetch_src;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef QSPI_RESPONDER_WRAP_EN
        return {a[ADDR_W-1:4], a[3:0] + 4'd1};
`else
        return a + 1'b1;
`endif
    endfunction

    assign cmd_en  = !cs && (state_q inside {Asleep, Idle, Cmd});
    assign addr_en = !cs && (state_q == Addr);

    qspi_shift_in #(.LANE_W(1), .COUNT(8)) u_cmd (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cs),
        .en_i    (cmd_en),
        .din_i   (io_in[0]),
        .value_o (cmd_val),
        .done_o  (cmd_done)
    );

    qspi_shift_in #(.LANE_W(NIBBLE_W), .COUNT(ADDR_W / NIBBLE_W)) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cs),
        .en_i    (addr_en),
        .din_i   (io_in),
        .value_o (addr_val),
        .done_o  (addr_done)
    );

    // with two dummy cycles the first fetch coincides with the last address nibble
    assign fetch_src = (state_q == Addr) ? addr_val : addr_q;

    assign io_out   = io_out_q;
    assign io_oe    = io_oe_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign powered  = powered_q;

    // next-state and registered-output decode; addr_q always holds the next byte to fetch
    always_comb begin
        state_d    = state_q;
        powered_d  = powered_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        half_d     = half_q;
        cnt_d      = cnt_q;
        io_out_d   = io_out_q;
        io_oe_d    = io_oe_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        fetch      = 1'b0;
        if (cs) begin
            state_d = powered_q ? Idle : Asleep;
            io_oe_d = 1'b0;
        end else begin
            case (state_q)
                Asleep, Idle: state_d = Cmd;
                Cmd: begin
                    if (cmd_done) begin
                        case (cmd_val)
                            CmdReset: begin
                                powered_d = 1'b0;
                                state_d   = Ignore;
                            end
                            CmdPowerUp: begin
                                powered_d = 1'b1;
                                state_d   = Ignore;
                            end
                            CmdRead: state_d = powered_q ? Addr : Ignore;
                            default: state_d = Ignore;
                        endcase
                    end
                end
                Addr: begin
                    if (addr_done) begin
                        state_d = Dummy;
                        cnt_d   = '0;
                        addr_d  = addr_val;
                        fetch   = (DUMMY_CYCLES == 2);
                    end
                end
                Dummy: begin
                    cnt_d = cnt_q + 1'b1;
                    fetch = (DUMMY_CYCLES > 2) && (cnt_q == CNT_W'(DUMMY_CYCLES - 3));
                    byte_d = (cnt_q == CNT_W'(DUMMY_CYCLES - 2)) ? mem_rdata : byte_q;
                    if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                        state_d  = Data;
                        io_oe_d  = 1'b1;
                        io_out_d = byte_q[7:4];
                        half_d   = 1'b0;
                        fetch    = 1'b1;
                    end
                end
                Data: begin
                    io_out_d = half_q ? byte_q[7:4] : byte_q[3:0];
                    byte_d   = half_q ? byte_q : mem_rdata;
                    half_d   = !half_q;
                    fetch    = half_q;
                end
                default: state_d = state_q;
            endcase
        end
        if (fetch) begin
            mem_en_d   = 1'b1;
            mem_addr_d = fetch_src;
            addr_d     = next_addr(fetch_src);
        end
    end

    // state and output registers; async reset also forgets the power-up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= Asleep;
            powered_q  <= 1'b0;
            addr_q     <= '0;
            byte_q     <= '0;
            half_q     <= 1'b0;
            cnt_q      <= '0;
            io_out_q   <= '0;
            io_oe_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            powered_q  <= powered_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
            half_q     <= half_d;
            cnt_q      <= cnt_d;
            io_out_q   <= io_out_d;
            io_oe_q    <= io_oe_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: table-driven transactions plus abort, fetch-timing and async-reset sequences
module tb_qspi_flash_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b1;
    logic [3:0]  io_in = 4'h0;
    logic [3:0]  io_out;
    logic        io_oe, mem_en, powered;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    int          checks = 0;
    int          failures = 0;

    logic        obs_oe  [64];
    logic [3:0]  obs_nib [64];
    logic        obs_men [64];
    logic [23:0] obs_ma  [64];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nibs;
        int          nb;
        logic [31:0] bytes;
        logic        pw;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    assign mem_rdata = mem_en ? mem_addr[7:0] : 8'h00;

    qspi_flash_responder dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .powered   (powered)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic rec(input int i);
        obs_oe[i]  = io_oe;
        obs_nib[i] = io_out;
        obs_men[i] = mem_en;
        obs_ma[i]  = mem_addr;
    endtask

    // holds cs low for n edges: 8 command bits, nibs address nibbles, then idle nibbles
    task automatic frame(input logic [7:0] cmd, input logic [23:0] addr, input int nibs, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k > 0) rec(k - 1);
            cs = 1'b0;
            if (k < 8) io_in = {3'b000, cmd[7-k]};
            else if (k < 8 + nibs) io_in = addr[4*(nibs-1-(k-8)) +: 4];
            else io_in = 4'h0;
        end
    endtask

    task automatic close(input int n);
        @(negedge clk);
        rec(n - 1);
        cs = 1'b1;
        io_in = 4'h0;
        @(negedge clk);
        rec(n);
    endtask

    task automatic chk_no_oe(input string name, input int n);
        logic any_oe;
        any_oe = 1'b0;
        for (int k = 0; k < n; k++) any_oe |= obs_oe[k];
        chk(name, any_oe, 1'b0);
    endtask

    initial begin
        int n;
        logic [7:0] b;
        tbl[0] = '{8'hEB, 24'h000010, 6, 0, 32'h0, 1'b0};
        tbl[1] = '{8'hAB, 24'h000000, 0, 0, 32'h0, 1'b1};
        tbl[2] = '{8'hEB, 24'h000010, 6, 3, 32'h00121110, 1'b1};
`ifdef QSPI_RESPONDER_WRAP_EN
        tbl[3] = '{8'hEB, 24'h00001E, 6, 4, 32'h11101F1E, 1'b1};
`else
        tbl[3] = '{8'hEB, 24'h00001E, 6, 4, 32'h21201F1E, 1'b1};
`endif
        tbl[4] = '{8'h99, 24'h000000, 0, 0, 32'h0, 1'b0};
        tbl[5] = '{8'hEB, 24'h000020, 6, 0, 32'h0, 1'b0};
        tbl[6] = '{8'hAB, 24'h000000, 0, 0, 32'h0, 1'b1};

        #1 rst = 1'b0;
        #2;
        chk("rst_oe", io_oe, 1'b0);
        chk("rst_out", io_out, 4'h0);
        chk("rst_men", mem_en, 1'b0);
        chk("rst_maddr", mem_addr, 24'h0);
        chk("rst_pw", powered, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            n = (tbl[i].nibs != 0) ? 28 : 10;
            frame(tbl[i].cmd, tbl[i].addr, tbl[i].nibs, n);
            close(n);
            if (tbl[i].nb > 0) begin
                chk($sformatf("row%0d_oe_pre", i), obs_oe[18], 1'b0);
                chk($sformatf("row%0d_oe_first", i), obs_oe[19], 1'b1);
                for (int j = 0; j < tbl[i].nb; j++) begin
                    b = tbl[i].bytes[8*j +: 8];
                    chk($sformatf("row%0d_b%0d_hi", i, j), obs_nib[19+2*j], b[7:4]);
                    chk($sformatf("row%0d_b%0d_lo", i, j), obs_nib[20+2*j], b[3:0]);
                end
            end else begin
                chk_no_oe($sformatf("row%0d_no_oe", i), n);
            end
            chk($sformatf("row%0d_gap_oe", i), obs_oe[n], 1'b0);
            chk($sformatf("row%0d_gap_men", i), obs_men[n], 1'b0);
            chk($sformatf("row%0d_pw", i), powered, tbl[i].pw);
        end

        frame(8'hEB, 24'h000FFF, 3, 11);
        close(11);
        chk_no_oe("abort_no_oe", 11);
        chk("abort_gap_oe", obs_oe[11], 1'b0);
        frame(8'hEB, 24'h000005, 6, 28);
        close(28);
        chk("fresh_b0_hi", obs_nib[19], 4'h0);
        chk("fresh_b0_lo", obs_nib[20], 4'h5);
        chk("fresh_b1_lo", obs_nib[22], 4'h6);
        chk("fresh_b3_lo", obs_nib[26], 4'h8);
        chk("men_early", obs_men[16], 1'b0);
        chk("men_first", obs_men[17], 1'b1);
        chk("maddr_first", obs_ma[17], 24'h000005);
        chk("men_gap", obs_men[18], 1'b0);
        chk("men_second", obs_men[19], 1'b1);
        chk("maddr_second", obs_ma[19], 24'h000006);
        chk("men_low", obs_men[20], 1'b0);
        chk("maddr_third", obs_ma[21], 24'h000007);

        frame(8'hEB, 24'h000040, 6, 22);
        chk("arst_pre_oe", obs_oe[20], 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_oe", io_oe, 1'b0);
        chk("arst_out", io_out, 4'h0);
        chk("arst_men", mem_en, 1'b0);
        chk("arst_maddr", mem_addr, 24'h0);
        chk("arst_pw", powered, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cs = 1'b1;
        frame(8'hEB, 24'h000010, 6, 28);
        close(28);
        chk_no_oe("post_arst_no_oe", 28);
        chk("post_arst_pw", powered, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI flash target that answers the cache-side QSPI initiator: it decodes the reset, power-up and quad-read commands and streams nibbles from a backing byte memory. It serves as the device model in simulation and FPGA loopback benches, and as the far end for protocol checks. It runs on the same `clk` as the initiator and samples the bus on every rising edge while `cs` is low.

## Interface
Parameters:
- `ADDR_W`, 24: address bits received; must be a multiple of 4.
- `DUMMY_CYCLES`, 6: dummy cycles between the address and the first data nibble; must be at least 2.

Ports:
- `clk`  in  1  system clock; also serves as the QSPI bit clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select, active low.
- `io_in`  in  4  bus lines sampled from the initiator.
- `io_out`  out  4  data nibble driven toward the initiator.
- `io_oe`  out  1  output enable for `io_out`; high only while data is being driven.
- `mem_en`  out  1  read strobe to the backing memory.
- `mem_addr`  out  ADDR_W  byte address for the read.
- `mem_rdata`  in  8  read data, valid exactly 1 cycle after `mem_en`.
- `powered`  out  1  high once a power-up command has executed.

## Operation
- Command codes come from the shared `cmd_t`: `CmdReset`=8'h99, `CmdPowerUp`=8'hAB, `CmdRead`=8'hEB.
- Command phase: 8 cycles, 1 bit per cycle on `io_in[0]`, MSB first.
- Address phase (read only): ADDR_W/4 cycles on `io_in[3:0]`, MSB nibble first.
- Dummy phase: `DUMMY_CYCLES` cycles. Data phase: high nibble of each byte first; the byte address increments after each low nibble.
- States:
  - `Asleep`: left on power-up.
  - `Idle`: waiting for `cs` to fall.
  - `Cmd`: shifting in the command.
  - `Addr`: shifting in the address.
  - `Dummy`: counting dummy cycles.
  - `Data`: driving nibbles.
  - `Ignore`: discarding the rest of the transaction.
- Command decode happens on the edge that captures bit 0:
  - `CmdReset`: clears `powered`, then `Ignore`.
  - `CmdPowerUp`: sets `powered`, then `Ignore`.
  - `CmdRead` with `powered` high: goes to `Addr`.
  - `CmdRead` while not powered, or any unknown code: goes to `Ignore`.
- `cs` high in any state returns to `Idle` (or `Asleep` if not powered) on the next edge. An unfinished command is discarded and `io_oe` drops.
- `cs` falling while in `Asleep`: enters `Cmd`. Only `CmdPowerUp` or `CmdReset` take effect there.
- The data stream continues until `cs` rises; there is no length limit.
- The address counter is ADDR_W bits and wraps modulo 2^ADDR_W when linear.

## Timing
- Reset values: state `Asleep`, `powered`=0, `io_oe`=0, `io_out`=0, `mem_en`=0, `mem_addr`=0.
- All outputs are registered.
- The last address nibble is captured at edge A. Dummy cycles occupy edges A+1..A+`DUMMY_CYCLES`.
- `mem_en` pulses for the first byte in the cycle after edge A+`DUMMY_CYCLES`−2. The byte is registered at edge A+`DUMMY_CYCLES`−1.
- `io_oe` rises and the first high nibble appears on `io_out` after edge A+`DUMMY_CYCLES`. Each subsequent nibble follows 1 cycle later.
- While the high nibble of byte N is on the bus, `mem_en` pulses with `mem_addr`=N+1. The rdata is captured at the same edge that puts the low nibble of byte N on the bus.
- `cs` rising: `io_oe`=0 and `mem_en`=0 after that edge.
- Async reset mid-transfer: outputs take their reset values immediately; `powered` is lost.

## Configuration
- `QSPI_RESPONDER_WRAP_EN` defined: the data-phase address wraps within the aligned 16-byte line of the start address, so only the low 4 bits increment. This matches the cache line fill order.
- Macro undefined: linear increment across the full ADDR_W space.

## Structure
- `cmd_t` and its code values, the nibble width, and default `DUMMY_CYCLES` live in the shared QSPI package/header already included by the initiator.
- The responder's state enum is local to the module.
- One sub-module: `qspi_shift_in`, a parameterized serial/quad shift register with a done flag. It is instantiated for the command (1-bit lanes) and the address (4-bit lanes).

## Test plan
- Reset, then `CmdRead` 8'hEB before power-up → `io_oe` stays 0 for the whole transaction; `powered`=0.
- `CmdPowerUp` 8'hAB, then `cs` high → `powered`=1.
- Read at address 0x000010 with memory holding byte value k at address k:
  - nibbles 1,0,1,1,1,2,… appear;
  - the first nibble is driven exactly 6 cycles after the last address nibble.
- Read at 0x00001E for 4 bytes:
  - with the macro → bytes 1E,1F,10,11;
  - without it → 1E,1F,20,21.
- Raise `cs` mid-address, then issue a fresh read at 0x000005 → no stale address bits; data starts at 05; `io_oe` was 0 during the idle gap.
- `CmdReset` 8'h99 after a power-up → `powered`=0; a subsequent read is ignored.
